mux_sel_arbiter: RTL and testbench

//   Two-requester round-robin arbiter that drives the select line of the 2:1 mux

---
 rtl/mux_sel_arbiter.sv | 106 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// A hold counter bounds grant tenure under contention so neither source starves.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic       s,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          last_reg, last_next;
    logic          s_next;
    logic          preempt_next;
    logic [1:0]    gnt_next;
    logic          grant_en;
    logic          grant_idx;
    logic          own;
    logic          other;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_next    = last_reg;
        s_next       = s;
        preempt_next = 1'b0;
        grant_en     = 1'b0;
        grant_idx    = 1'b0;
        own          = (state_reg == GRANT1);
        other        = ~own;

        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_en  = 1'b1;
                    // On a tie the source that did not win last time goes first.
                    grant_idx = (req == 2'b11) ? ~last_reg : req[1];
                end
            end
            GRANT0, GRANT1: begin
                if (!req[own]) begin
                    if (req[other]) begin
                        grant_en  = 1'b1;
                        grant_idx = other;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (req[other] && cnt_reg == CNT_MAX) begin
                    grant_en     = 1'b1;
                    grant_idx    = other;
                    preempt_next = 1'b1;
                end else if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (grant_en) begin
            state_next = grant_idx ? GRANT1 : GRANT0;
            cnt_next   = '0;
            last_next  = grant_idx;
            s_next     = grant_idx;
        end
    end

    // Grant lines are decoded from the next state so they register alongside it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
        assign gnt_next[gi] = (state_next == ((gi == 0) ? GRANT0 : GRANT1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            s         <= 1'b0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
            s         <= s_next;
            gnt       <= gnt_next;
            busy      <= |gnt_next;
            preempt   <= preempt_next;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: two instances (MAX_HOLD=8 and MAX_HOLD=1) share req/rst
// and are compared every cycle against a tenure-based reference model.
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic       s_o     [2];
    logic [1:0] gnt_o   [2];
    logic       busy_o  [2];
    logic       pre_o   [2];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_HOLD(8), .CW(4)) dut8 (
        .clk(clk), .rst(rst), .req(req),
        .s(s_o[0]), .gnt(gnt_o[0]), .busy(busy_o[0]), .preempt(pre_o[0])
    );

    mux_sel_arbiter #(.MAX_HOLD(1), .CW(2)) dut1 (
        .clk(clk), .rst(rst), .req(req),
        .s(s_o[1]), .gnt(gnt_o[1]), .busy(busy_o[1]), .preempt(pre_o[1])
    );

    // Reference model: owner (-1 = idle), cycles held so far, last winner.
    int maxh   [2] = '{8, 1};
    int m_own  [2];
    int m_ten  [2];
    bit m_last [2];
    bit m_s    [2];
    bit m_pre  [2];

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_ten[i] = 0; m_last[i] = 1'b1; m_s[i] = 1'b0; m_pre[i] = 1'b0;
        end
    endfunction

    function automatic void model_grant(int i, int w);
        m_own[i] = w; m_ten[i] = 1; m_last[i] = w[0]; m_s[i] = w[0];
    endfunction

    function automatic void model_step(logic [1:0] r);
        for (int i = 0; i < 2; i++) begin
            m_pre[i] = 1'b0;
            if (m_own[i] < 0) begin
                if (r == 2'b11)      model_grant(i, m_last[i] ? 0 : 1);
                else if (r == 2'b01) model_grant(i, 0);
                else if (r == 2'b10) model_grant(i, 1);
            end else begin
                int k = m_own[i];
                int o = 1 - k;
                if (!r[k]) begin
                    if (r[o]) model_grant(i, o);
                    else      m_own[i] = -1;
                end else if (r[o] && m_ten[i] >= maxh[i]) begin
                    model_grant(i, o);
                    m_pre[i] = 1'b1;
                end else begin
                    m_ten[i]++;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic [1:0] eg;
            eg = (m_own[i] == 0) ? 2'b01 : (m_own[i] == 1) ? 2'b10 : 2'b00;
            chk($sformatf("%s/h%0d/gnt", tag, maxh[i]), gnt_o[i], eg);
            chk($sformatf("%s/h%0d/s", tag, maxh[i]), {1'b0, s_o[i]}, {1'b0, m_s[i]});
            chk($sformatf("%s/h%0d/busy", tag, maxh[i]), {1'b0, busy_o[i]}, {1'b0, m_own[i] >= 0});
            chk($sformatf("%s/h%0d/preempt", tag, maxh[i]), {1'b0, pre_o[i]}, {1'b0, m_pre[i]});
        end
    endtask

    // Called 1 time unit after a rising edge; asserts rst between edges.
    task automatic apply_reset(input string tag);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all(tag);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cycle(input logic [1:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_step(r);
        #1 check_all(tag);
    endtask

    initial begin
        logic [1:0] r;
        rst = 1'b1;
        req = 2'b00;
        model_reset();
        #1 check_all("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single requester, then drop: s must hold 0 in idle.
        for (int c = 0; c < 3; c++) cycle(2'b01, "single0");
        for (int c = 0; c < 2; c++) cycle(2'b00, "drop");

        // Constant contention from reset: 8-cycle tenures / every-cycle toggling.
        apply_reset("rst_busy_pre");
        for (int c = 0; c < 26; c++) cycle(2'b11, "contend");

        // Mid-grant asynchronous reset, then long uncontested hold and late request.
        apply_reset("rst_midgrant");
        for (int c = 0; c < 20; c++) cycle(2'b01, "hold0");
        for (int c = 0; c < 3; c++)  cycle(2'b11, "late_req1");

        // Hand-off at cnt=3 without idle bubble.
        apply_reset("rst_handoff");
        for (int c = 0; c < 4; c++) cycle(2'b01, "pre_handoff");
        for (int c = 0; c < 2; c++) cycle(2'b10, "handoff");
        cycle(2'b11, "tie_after_handoff");

        // Randomized sticky requests with occasional asynchronous reset.
        r = 2'b00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) r = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) apply_reset("rand_rst");
            cycle(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
